// File: rtl/dffram_defs.sv
// dffram_defs: sweep-engine state encodings and address-width helper for dffram_dp
package dffram_defs;

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/dffram_clr_fsm.sv
// dffram_clr_fsm: zeroise sequencer, one word cleared per cycle from address 0 upward
module dffram_clr_fsm
   import dffram_defs::*;
#(
   parameter int WORDS      = 256,
   parameter bit CLR_ON_RST = 1'b1,
   localparam int AW        = clog2(WORDS)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CLR,
   output logic          BUSY,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   state_t state;

   always_ff @(posedge CLK)
      if (RST) begin
         state    <= CLR_ON_RST ? SWEEP : IDLE;
         clr_addr <= '0;
      end else if (state == IDLE) begin
         if (CLR) begin
            state    <= SWEEP;
            clr_addr <= '0;
         end
      end else begin
         clr_addr <= clr_addr + AW'(1);
         if (clr_addr == AW'(WORDS - 1)) state <= IDLE;
      end

   assign BUSY   = state == SWEEP;
   assign clr_we = BUSY;

endmodule

// File: rtl/dffram_dp.sv
// dffram_dp: flip-flop RAM with a byte-write read/write port A, a read-only port B
// and a zeroise engine that owns the write port while it sweeps.
module dffram_dp
   import dffram_defs::*;
#(
   parameter int WORDS      = 256,
   parameter int DW         = 32,
   parameter bit OUT_REG    = 1'b0,
   parameter bit CLR_ON_RST = 1'b1,
   localparam int AW        = clog2(WORDS),
   localparam int NB        = DW / 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CLR,
   output logic          BUSY,
   input  logic          EN0,
   input  logic [NB-1:0] WE0,
   input  logic [AW-1:0] A0,
   input  logic [DW-1:0] Di0,
   output logic [DW-1:0] Do0,
   input  logic          EN1,
   input  logic [AW-1:0] A1,
   output logic [DW-1:0] Do1
);

   logic [DW-1:0] mem [WORDS];
   logic          clr_we;
   logic [AW-1:0] clr_addr;
   logic [AW-1:0] wa;
   logic [NB-1:0] wbe;
   logic [DW-1:0] wd, wold, wnew;
   logic          wok, rok0, rok1, acc0, acc1;
   logic [DW-1:0] r0, r1, q0, q1;
   logic          ld0, ld1;

   dffram_clr_fsm #(.WORDS(WORDS), .CLR_ON_RST(CLR_ON_RST)) u_fsm (
      .CLK      (CLK),
      .RST      (RST),
      .CLR      (CLR),
      .BUSY     (BUSY),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // the sweep overrides port A entirely; out-of-range addresses never touch the array
   always_comb begin
      wa   = clr_we ? clr_addr : A0;
      wd   = clr_we ? '0 : Di0;
      wbe  = clr_we ? '1 : (EN0 ? WE0 : '0);
      wok  = int'(wa) < WORDS;
      wold = wok ? mem[wa] : '0;
      acc0 = !BUSY && EN0;
      acc1 = !BUSY && EN1;
      rok0 = int'(A0) < WORDS;
      rok1 = int'(A1) < WORDS;
   end

   for (genvar b = 0; b < NB; b++) begin : g_byte
      assign wnew[8*b +: 8] = wbe[b] ? wd[8*b +: 8] : wold[8*b +: 8];
   end

   always_ff @(posedge CLK)
      if (wok && |wbe) mem[wa] <= wnew;

   always_ff @(posedge CLK)
      if (RST) begin
         r0  <= '0;
         r1  <= '0;
         q0  <= '0;
         q1  <= '0;
         ld0 <= 1'b0;
         ld1 <= 1'b0;
      end else begin
         if (acc0) r0 <= rok0 ? mem[A0] : '0;
         if (acc1) r1 <= rok1 ? mem[A1] : '0;
         ld0 <= acc0;
         ld1 <= acc1;
         if (ld0) q0 <= r0;
         if (ld1) q1 <= r1;
      end

   assign Do0 = OUT_REG ? q0 : r0;
   assign Do1 = OUT_REG ? q1 : r1;

endmodule

// File: doc/dffram_dp.md
# dffram_dp

Parametrised dual-port successor to the single-port byte-write DFFRAM macro. Provides one read/write port (A) and one read-only port (B) over a flip-flop memory array, with optional output pipeline register. A built-in zeroise engine clears the array after reset or on request. Used as register-file / scratchpad storage where a second concurrent read path is needed, e.g. cache tag and data sideband or a debug read-back.

## Interface
- WORDS, 256: number of words, 2..1024; need not be a power of two.
- DW, 32: data width, multiple of 8.
- AW, derived = ceil(log2(WORDS)): address width, localparam, not overridable.
- OUT_REG, 0: 1 adds one output register stage on both read ports.
- CLR_ON_RST, 1: 1 starts a zeroise sweep after every reset.

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- CLR  in  1  single-cycle pulse requesting a zeroise sweep.
- BUSY  out  1  high while a sweep is in progress.
- EN0  in  1  port A enable.
- WE0  in  DW/8  port A byte write enables; bit i covers Di0[8i+7:8i].
- A0  in  AW  port A address.
- Di0  in  DW  port A write data.
- Do0  out  DW  port A read data.
- EN1  in  1  port B enable.
- A1  in  AW  port B address.
- Do1  out  DW  port B read data.

## Operation
- States: IDLE, SWEEP. A counter clr_addr (AW bits) is used in SWEEP only.
- RST high: state := SWEEP if CLR_ON_RST else IDLE; clr_addr := 0; Do0, Do1 and the pipeline registers := 0. The array itself is not reset.
- SWEEP: each cycle, writes all-zero to mem[clr_addr] and increments clr_addr. On the cycle clr_addr = WORDS-1, state := IDLE. A sweep takes exactly WORDS cycles.
- BUSY = (state == SWEEP). While BUSY is high, EN0/EN1 are ignored: no user writes, and Do0/Do1 hold their values.
- CLR in IDLE: state := SWEEP, clr_addr := 0. CLR during SWEEP is ignored; the sweep does not restart.
- RST mid-sweep: the sweep restarts from address 0 (or stops if CLR_ON_RST=0).
- Port A, IDLE, EN0=1: Do0 <= mem[A0] (read-first: old data). For each i with WE0[i]=1, byte i of mem[A0] <= byte i of Di0. EN0=0: no access, Do0 holds.
- Port B, IDLE, EN1=1: Do1 <= mem[A1]. EN1=0: Do1 holds.
- Same-address collision (A0 write and A1 read, same cycle): Do1 returns the old data. The write completes normally.
- Out-of-range address (>= WORDS): the write is dropped and the read returns 0.

## Timing
- OUT_REG=0: read data is valid on Do* at the edge following the enabled cycle (latency 1).
- OUT_REG=1: latency 2. The second stage loads whenever the first stage was loaded on the previous cycle, so Do* hold otherwise.
- A write is visible to either port on any read issued in the following cycle or later.
- After RST deasserts with CLR_ON_RST=1, BUSY stays high for WORDS cycles. The first accepted access is in cycle WORDS after deassertion.
- No combinational path exists from inputs to outputs.

## Structure
- Shared package/include file dffram_defs: state encodings (IDLE=0, SWEEP=1) and a clog2 constant function for AW.
- Sub-module dffram_clr_fsm holds the state register, clr_addr counter and BUSY, and outputs a clear-write strobe plus address. The top level holds the array, the port muxing and the output pipeline.
- The write port muxes between the sweep and port A. Byte-enable write logic is a generate loop over DW/8.

## Test plan
- Reset sweep: WORDS=16, CLR_ON_RST=1; pre-load garbage via backdoor, pulse RST -> BUSY high exactly 16 cycles, then every word reads 0x00000000.
- Byte writes: write 0xAABBCCDD at addr 5 with WE0=4'b1111, then 0x11223344 with WE0=4'b0101 -> read of 5 returns 0xAA22CC44.
- Collision: same cycle, port A writes 0xDEADBEEF to addr 3 (old 0x0) and port B reads addr 3 -> Do1=0x0; next-cycle read of addr 3 on B -> 0xDEADBEEF.
- Latency: OUT_REG=1; read addr 7 (=0x55) on cycle n -> Do0=0x55 at n+2, unchanged at n+3 with EN0=0.
- CLR and RST mid-sweep: CLR pulse in IDLE, then RST at sweep cycle 6 -> sweep restarts and BUSY lasts WORDS cycles from RST deassertion. A CLR during the sweep does not extend it.
- Non-power-of-two: WORDS=12; write 0xFFFFFFFF to addr 13 -> no array change; a read of addr 13 returns 0; addresses 0..11 are unaffected.
